// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-window shift ring.
//   - occ_state_e    : occupancy state (EMPTY / FILLING / FULL)
//   - IMEM_*_DEF     : default entry width and depth
//   - entry_lo()     : low bit index of entry idx inside a flattened window
package imem_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } occ_state_e;

    localparam int IMEM_WIDTH_DEF = 16;
    localparam int IMEM_DEPTH_DEF = 64;

    function automatic int entry_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/imem_occupancy.sv
// imem_occupancy: occupancy tracker for imem_shift_ring.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   clear_i         : synchronous flush (highest priority)
//   rotate_i        : rotate request (blocks pushes)
//   in_valid_i      : push request
//   in_ready_o      : push can be accepted (independent of in_valid_i)
//   push_o          : push accepted this cycle
//   count_o         : occupied entries, 0..DEPTH
//   full_o, empty_o : decoded from the occupancy state
module imem_occupancy
    import imem_pkg::*;
#(
    parameter int DEPTH     = IMEM_DEPTH_DEF,
    parameter int OVERWRITE = 1,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        rotate_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        push_o,
    output logic [AW:0] count_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LAST_C  = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

    occ_state_e  state_q, state_d;
    logic [AW:0] count_q, count_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clear_i) begin
            state_d = ST_EMPTY;
            count_d = '0;
        end else if (push_o) begin
            // A push in FULL (overwrite mode) drops the oldest entry, so count saturates.
            count_d = (count_q == DEPTH_C) ? count_q : count_q + ONE_C;
            case (state_q)
                ST_EMPTY:   state_d = ST_FILLING;
                ST_FILLING: state_d = (count_q == LAST_C) ? ST_FULL : ST_FILLING;
                ST_FULL:    state_d = ST_FULL;
                default:    state_d = ST_EMPTY;
            endcase
        end
    end

    // Outputs
    always_comb begin
        full_o     = (state_q == ST_FULL);
        empty_o    = (state_q == ST_EMPTY);
        in_ready_o = !clear_i && !rotate_i && !(full_o && (OVERWRITE == 0));
        push_o     = in_valid_i && in_ready_o;
        count_o    = count_q;
    end

endmodule

// File: rtl/imem_shift_ring.sv
// imem_shift_ring: DEPTH x WIDTH instruction-window shift memory.
// New entries enter at index 0 and older ones shift up; the occupied region
// can be rotated in place. Optional feature macro: IMEM_SHIFT_RING_PARITY_EN
// (per-entry even parity plus a sticky parity_err output).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   clear               : synchronous flush of contents and occupancy
//   in_valid/in_data    : push port, in_ready = push acceptable
//   rotate              : rotate occupied region by one position
//   rd_addr/rd_data     : registered read port, 1-cycle latency, pre-edge contents
//   data_out            : registered flattened window (lags mem by one cycle)
//   count, full, empty  : occupancy
//   parity_err          : (macro only) sticky parity error flag
module imem_shift_ring
    import imem_pkg::*;
#(
    parameter int WIDTH     = IMEM_WIDTH_DEF,
    parameter int DEPTH     = IMEM_DEPTH_DEF,
    parameter int OVERWRITE = 1,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic                   rotate,
    input  logic [AW-1:0]          rd_addr,
    output logic [WIDTH-1:0]       rd_data,
    output logic [WIDTH*DEPTH-1:0] data_out,
    output logic [AW:0]            count,
    output logic                   full,
    output logic                   empty
`ifdef IMEM_SHIFT_RING_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    logic                   push_w;
    logic [AW:0]            count_w;
    logic [AW:0]            last_w;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [WIDTH*DEPTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0]       rd_data_q, rd_data_d;

    imem_occupancy #(
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE),
        .AW        (AW)
    ) u_occ (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear),
        .rotate_i   (rotate),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .push_o     (push_w),
        .count_o    (count_w),
        .full_o     (full),
        .empty_o    (empty)
    );

    assign count  = count_w;
    assign last_w = count_w - (AW + 1)'(1);

    // Shift / rotate datapath
    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
        end else if (rotate) begin
            // Only the occupied region [0, count) rotates; the top occupied
            // entry wraps to index 0.
            if (int'(count_w) >= 2) begin
                for (int i = 1; i < DEPTH; i++)
                    if (i < int'(count_w)) mem_d[i] = mem_q[i-1];
                mem_d[0] = mem_q[last_w[AW-1:0]];
            end
        end else if (push_w) begin
            for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
            mem_d[0] = in_data;
        end
    end

    // Output registers sample the pre-edge memory contents.
    always_comb begin
        data_out_d = '0;
        for (int i = 0; i < DEPTH; i++)
            data_out_d[entry_lo(i, WIDTH) +: WIDTH] = mem_q[i];
        rd_data_d = (int'(rd_addr) < DEPTH) ? mem_q[rd_addr] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            data_out_q <= '0;
            rd_data_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            data_out_q <= data_out_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_data  = rd_data_q;

`ifdef IMEM_SHIFT_RING_PARITY_EN
    logic [DEPTH-1:0] par_q, par_d;
    logic             par_err_q, par_err_d;
    logic             mismatch_w;

    // Parity bits follow exactly the same moves as their entries.
    always_comb begin
        par_d = par_q;
        if (clear) begin
            par_d = '0;
        end else if (rotate) begin
            if (int'(count_w) >= 2) begin
                for (int i = 1; i < DEPTH; i++)
                    if (i < int'(count_w)) par_d[i] = par_q[i-1];
                par_d[0] = par_q[last_w[AW-1:0]];
            end
        end else if (push_w) begin
            for (int i = 1; i < DEPTH; i++) par_d[i] = par_q[i-1];
            par_d[0] = ^in_data;
        end
    end

    always_comb begin
        mismatch_w = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (i < int'(count_w) && ((^mem_q[i]) != par_q[i])) mismatch_w = 1'b1;
        par_err_d = clear ? 1'b0 : (par_err_q | mismatch_w);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q     <= '0;
            par_err_q <= 1'b0;
        end else begin
            par_q     <= par_d;
            par_err_q <= par_err_d;
        end
    end

    assign parity_err = par_err_q;
`endif

endmodule

// File: tb/tb_imem_shift_ring.sv
module tb_imem_shift_ring;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_clear = 0, a_valid = 0, a_rot = 0;
    logic [15:0] a_data = '0;
    logic [1:0]  a_rdaddr = '0;
    logic        a_ready, a_full, a_empty;
    logic [15:0] a_rd;
    logic [63:0] a_dout;
    logic [2:0]  a_cnt;

    logic        b_clear = 0, b_valid = 0, b_rot = 0;
    logic [15:0] b_data = '0;
    logic [1:0]  b_rdaddr = '0;
    logic        b_ready, b_full, b_empty;
    logic [15:0] b_rd;
    logic [63:0] b_dout;
    logic [2:0]  b_cnt;

`ifdef IMEM_SHIFT_RING_PARITY_EN
    logic a_perr, b_perr;
    logic pbit;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_shift_ring #(.WIDTH(16), .DEPTH(4), .OVERWRITE(1)) dut_a (
        .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_valid), .in_data(a_data),
        .in_ready(a_ready), .rotate(a_rot), .rd_addr(a_rdaddr), .rd_data(a_rd),
        .data_out(a_dout), .count(a_cnt), .full(a_full), .empty(a_empty)
`ifdef IMEM_SHIFT_RING_PARITY_EN
        , .parity_err(a_perr)
`endif
    );

    imem_shift_ring #(.WIDTH(16), .DEPTH(4), .OVERWRITE(0)) dut_b (
        .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_valid), .in_data(b_data),
        .in_ready(b_ready), .rotate(b_rot), .rd_addr(b_rdaddr), .rd_data(b_rd),
        .data_out(b_dout), .count(b_cnt), .full(b_full), .empty(b_empty)
`ifdef IMEM_SHIFT_RING_PARITY_EN
        , .parity_err(b_perr)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        repeat (2) @(posedge clk);
        #4 rst = 1'b0;
        #1;
        chk("rst_count", 64'(a_cnt), 64'd0);
        chk("rst_empty", 64'(a_empty), 64'd1);
        chk("rst_full", 64'(a_full), 64'd0);
        chk("rst_ready", 64'(a_ready), 64'd1);
        chk("rst_dout", a_dout, 64'd0);
        chk("rst_rd", 64'(a_rd), 64'd0);

        // push 1, 2, 3
        a_valid = 1; a_data = 16'h0001; tick;
        a_data = 16'h0002; tick;
        a_data = 16'h0003; tick;
        a_valid = 0;
        chk("push3_count", 64'(a_cnt), 64'd3);
        chk("push3_empty", 64'(a_empty), 64'd0);
        chk("push3_dout_lag", a_dout, 64'h0000_0000_0001_0002);
        tick;
        chk("push3_dout", a_dout, 64'h0000_0001_0002_0003);

        // rotate with in_valid held: no push, region {3,2,1} -> {1,3,2}
        a_rot = 1; a_valid = 1; a_data = 16'h0055;
        #1;
        chk("rot_ready", 64'(a_ready), 64'd0);
        tick;
        a_rot = 0; a_valid = 0;
        chk("rot_count", 64'(a_cnt), 64'd3);
        tick;
        chk("rot_dout", a_dout, 64'h0000_0002_0003_0001);

        // read entry 1 on the same edge as a push
        a_rdaddr = 2'd1; a_valid = 1; a_data = 16'h0004; tick;
        a_valid = 0;
        chk("rd_prepush", 64'(a_rd), 64'h3);
        chk("fill_count", 64'(a_cnt), 64'd4);
        chk("fill_full", 64'(a_full), 64'd1);
        chk("ow_ready_full", 64'(a_ready), 64'd1);
        tick;
        chk("fill_dout", a_dout, 64'h0002_0003_0001_0004);

`ifdef IMEM_SHIFT_RING_PARITY_EN
        // corrupt the parity of occupied entry 2
        pbit = dut_a.par_q[2];
        force dut_a.par_q[2] = ~pbit;
        tick;
        chk("perr_set", 64'(a_perr), 64'd1);
        release dut_a.par_q[2];
        tick;
        chk("perr_sticky", 64'(a_perr), 64'd1);
`endif

        // clear with in_valid: flush wins
        a_clear = 1; a_valid = 1; a_data = 16'h0077;
        #1;
        chk("clr_ready", 64'(a_ready), 64'd0);
        tick;
        a_clear = 0; a_valid = 0;
        chk("clr_count", 64'(a_cnt), 64'd0);
        chk("clr_empty", 64'(a_empty), 64'd1);
`ifdef IMEM_SHIFT_RING_PARITY_EN
        chk("perr_clr", 64'(a_perr), 64'd0);
`endif
        tick;
        chk("clr_dout", a_dout, 64'd0);

        // overwrite: push A..E into depth 4
        a_valid = 1;
        for (int k = 0; k < 5; k++) begin
            a_data = 16'h000A + 16'(k);
            tick;
        end
        a_valid = 0;
        chk("ow_count", 64'(a_cnt), 64'd4);
        chk("ow_full", 64'(a_full), 64'd1);
        a_rdaddr = 2'd3;
        tick;
        chk("ow_dout", a_dout, 64'h000B_000C_000D_000E);
        chk("ow_rd3", 64'(a_rd), 64'hB);

        // no-overwrite instance: fill, then hold in_valid
        b_valid = 1;
        for (int k = 1; k <= 4; k++) begin
            b_data = 16'(k);
            tick;
        end
        b_data = 16'h000F;
        #1;
        chk("nw_ready", 64'(b_ready), 64'd0);
        chk("nw_full", 64'(b_full), 64'd1);
        tick; tick;
        b_valid = 0;
        chk("nw_count", 64'(b_cnt), 64'd4);
        chk("nw_dout", b_dout, 64'h0001_0002_0003_0004);

        // rotate with a single entry is a no-op
        b_clear = 1; tick; b_clear = 0;
        b_valid = 1; b_data = 16'h0009; tick; b_valid = 0;
        b_rot = 1; tick; b_rot = 0;
        tick;
        chk("rot1_dout", b_dout, 64'h0000_0000_0000_0009);
        chk("rot1_count", 64'(b_cnt), 64'd1);

        // asynchronous reset mid-operation
        #3 rst = 1'b1;
        #1;
        chk("arst_count", 64'(a_cnt), 64'd0);
        chk("arst_dout", a_dout, 64'd0);
        chk("arst_empty", 64'(a_empty), 64'd1);
        #2 rst = 1'b0;
        a_valid = 1; a_data = 16'h0021; tick;
        a_valid = 0;
        tick;
        chk("arst_push", a_dout, 64'h0000_0000_0000_0021);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
